// File: rtl/rou_mng_node.sv
// rou_mng_node: management-message controller for one roubus ring node.
// Sits between the upstream and downstream ring ports. It executes RESET,
// ENUMERATE, CONTROL and REPORT requests addressed to this node, and it
// forwards all other traffic unchanged through a 1-deep registered output stage.
// Optional feature macro: ROU_MNG_NODE_STATS_EN. When it is defined, the node
// adds a 16-bit saturating counter of forwarded messages, and REPORT responses
// carry that counter in data bits 15:0.
module rou_mng_node #(
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int TWID = 5,
    parameter int BWID = (DWID == 512) ? 6 :
                         (DWID == 256) ? 5 :
                         (DWID == 128) ? 4 :
                         (DWID == 64)  ? 3 : 2,
    parameter int IDW  = 8,
    parameter int CWID = 32,
    parameter int WID  = 2 + DWID + AWID + BWID + TWID
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WID-1:0]  in_msg,
    input  logic            in_vld,
    output logic            in_rdy,
    output logic [WID-1:0]  out_msg,
    output logic            out_vld,
    input  logic            out_rdy,
    input  logic [DWID-1:0] status_in,
    output logic [IDW-1:0]  node_id,
    output logic            enumerated,
    output logic [CWID-1:0] ctrl_out,
    output logic            ctrl_pulse,
    output logic [7:0]      bad_cnt
);

    // Field positions inside a packed message {cmd, tags, bytes, addr, data}
    localparam int ALSB = DWID;
    localparam int TLSB = DWID + AWID + BWID;
    localparam int CLSB = TLSB + TWID;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    logic [WID-1:0]  outMsg_q;
    logic [IDW-1:0]  nodeId_q;
    logic            enum_q;
    logic [CWID-1:0] ctrl_q;
    logic            pulse_q;
    logic [7:0]      badCnt_q;

    logic [WID-1:0]  outMsg_d;
    logic [IDW-1:0]  nodeId_d;
    logic            enum_d;
    logic [CWID-1:0] ctrl_d;
    logic            pulse_d;

    logic            accept;
    logic            produce;
    logic            consumed;
    logic            badInc;
    logic            clrStats;
    logic            isMng;
    logic            hit;
    logic [1:0]      inCmd;
    logic [TWID-1:0] inTag;
    logic [IDW-1:0]  inId;
    logic [CWID-1:0] inCtrl;
    logic [DWID-1:0] reportData;

    assign inCmd  = in_msg[CLSB +: 2];
    assign inTag  = in_msg[TLSB +: TWID];
    assign inId   = in_msg[ALSB +: IDW];
    assign inCtrl = in_msg[0 +: CWID];

    assign isMng  = (inCmd == 2'b11);
    assign hit    = enum_q && (inId == nodeId_q);

    assign out_vld    = (state_q == FULL);
    assign in_rdy     = !out_vld || out_rdy;
    assign accept     = in_vld && in_rdy;
    assign out_msg    = outMsg_q;
    assign node_id    = nodeId_q;
    assign enumerated = enum_q;
    assign ctrl_out   = ctrl_q;
    assign ctrl_pulse = pulse_q;
    assign bad_cnt    = badCnt_q;

`ifdef ROU_MNG_NODE_STATS_EN
    logic [15:0] fwdCnt_q;

    assign reportData = {status_in[DWID-1:16], fwdCnt_q};

    // Forwarded-message counter; a RESET message clears it even though that message is itself forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            fwdCnt_q <= '0;
        end else if (accept && clrStats) begin
            fwdCnt_q <= '0;
        end else if (accept && produce && !consumed && (fwdCnt_q != 16'hFFFF)) begin
            fwdCnt_q <= fwdCnt_q + 16'd1;
        end
    end
`else
    assign reportData = status_in;
`endif

    // Decode the incoming message into its outgoing form and the node's next state
    always_comb begin
        outMsg_d = in_msg;
        nodeId_d = nodeId_q;
        enum_d   = enum_q;
        ctrl_d   = ctrl_q;
        pulse_d  = 1'b0;
        produce  = 1'b1;
        consumed = 1'b0;
        badInc   = 1'b0;
        clrStats = 1'b0;
        if (isMng && !inTag[0]) begin
            if (inTag == TWID'(0)) begin
                nodeId_d = '0;
                enum_d   = 1'b0;
                ctrl_d   = '0;
                clrStats = 1'b1;
            end else if (inTag == TWID'(2)) begin
                if (!enum_q) begin
                    if (inId != '1) begin
                        nodeId_d = inId;
                        enum_d   = 1'b1;
                        outMsg_d[ALSB +: IDW] = inId + IDW'(1);
                    end else begin
                        badInc = 1'b1;
                    end
                end
            end else if (inTag == TWID'(4)) begin
                if (hit) begin
                    ctrl_d   = inCtrl;
                    pulse_d  = 1'b1;
                    consumed = 1'b1;
                    outMsg_d[TLSB +: TWID] = TWID'(5);
                    outMsg_d[0 +: DWID]    = DWID'(inCtrl);
                end
            end else if (inTag == TWID'(6)) begin
                if (hit) begin
                    consumed = 1'b1;
                    outMsg_d[TLSB +: TWID] = TWID'(7);
                    outMsg_d[0 +: DWID]    = reportData;
                end
            end else begin
                produce = 1'b0;
                badInc  = 1'b1;
            end
        end
    end

    // Output-register FSM: holds one message until downstream takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            outMsg_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept && produce) begin
                        state_q  <= FULL;
                        outMsg_q <= outMsg_d;
                    end
                end
                FULL: begin
                    if (out_rdy) begin
                        if (accept && produce) begin
                            outMsg_q <= outMsg_d;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Node registers change only on an accepted message; a stalled input has no side effects
    always_ff @(posedge clk) begin
        if (rst) begin
            nodeId_q <= '0;
            enum_q   <= 1'b0;
            ctrl_q   <= '0;
            pulse_q  <= 1'b0;
            badCnt_q <= '0;
        end else begin
            pulse_q <= accept && pulse_d;
            if (accept) begin
                nodeId_q <= nodeId_d;
                enum_q   <= enum_d;
                ctrl_q   <= ctrl_d;
                if (badInc && (badCnt_q != 8'hFF)) begin
                    badCnt_q <= badCnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rou_mng_node.sv
// tb_rou_mng_node: table-driven directed bench for rou_mng_node, plus
// hand-written sequences for stall, streaming, saturation and reset cases.
module tb_rou_mng_node;

    localparam int DWID = 128;
    localparam int AWID = 32;
    localparam int TWID = 5;
    localparam int BWID = 4;
    localparam int IDW  = 8;
    localparam int CWID = 32;
    localparam int WID  = 2 + DWID + AWID + BWID + TWID;
    localparam int NVEC = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic [WID-1:0]  in_msg;
    logic            in_vld;
    logic            in_rdy;
    logic [WID-1:0]  out_msg;
    logic            out_vld;
    logic            out_rdy;
    logic [DWID-1:0] status_in;
    logic [IDW-1:0]  node_id;
    logic            enumerated;
    logic [CWID-1:0] ctrl_out;
    logic            ctrl_pulse;
    logic [7:0]      bad_cnt;

    int passCnt  = 0;
    int totalCnt = 0;

    // Free-running clock
    always #5 clk = ~clk;

    rou_mng_node dut (
        .clk        (clk),
        .rst        (rst),
        .in_msg     (in_msg),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_msg    (out_msg),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .status_in  (status_in),
        .node_id    (node_id),
        .enumerated (enumerated),
        .ctrl_out   (ctrl_out),
        .ctrl_pulse (ctrl_pulse),
        .bad_cnt    (bad_cnt)
    );

    typedef struct {
        logic [1:0]      cmd;
        logic [TWID-1:0] tags;
        logic [BWID-1:0] bytes;
        logic [AWID-1:0] addr;
        logic [DWID-1:0] data;
        logic [DWID-1:0] status;
        logic            eVld;
        logic [TWID-1:0] eTags;
        logic [AWID-1:0] eAddr;
        logic [DWID-1:0] eData;
        logic [IDW-1:0]  eNode;
        logic            eEnum;
        logic [CWID-1:0] eCtrl;
        logic            ePulse;
        logic [7:0]      eBad;
        logic            isRpt;
        logic            isFwd;
        logic            isClr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic [WID-1:0] mk(input logic [1:0] c, input logic [TWID-1:0] t,
                                          input logic [BWID-1:0] b, input logic [AWID-1:0] a,
                                          input logic [DWID-1:0] d);
        return {c, t, b, a, d};
    endfunction

    // Comparison helper shared by every check in the bench
    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one set of inputs
    task automatic applyStimulus(input logic [WID-1:0] m, input logic v, input logic r,
                                 input logic [DWID-1:0] s);
        in_msg    = m;
        in_vld    = v;
        out_rdy   = r;
        status_in = s;
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence
    initial begin : main
        logic [DWID-1:0] stS;
        logic [DWID-1:0] expData;
        logic [WID-1:0]  msgA;
        logic [WID-1:0]  msgB;
        logic [WID-1:0]  expMsg;
        int              fwdModel;

        stS      = {96'h0123_4567_89AB_CDEF_0011_2233, 32'h0000_CAFE};
        fwdModel = 0;

        vecs[0]  = '{2'b11, 5'd2, 4'd4, 32'h0000_0005, 128'h0, 128'h0,
                     1'b1, 5'd2, 32'h0000_0006, 128'h0, 8'h05, 1'b1, 32'h0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2'b11, 5'd2, 4'd4, 32'h0000_0009, 128'h77, 128'h0,
                     1'b1, 5'd2, 32'h0000_0009, 128'h77, 8'h05, 1'b1, 32'h0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{2'b11, 5'd4, 4'd4, 32'h0000_0005, 128'h1234_5678, 128'h0,
                     1'b1, 5'd5, 32'h0000_0005, 128'h1234_5678, 8'h05, 1'b1, 32'h1234_5678, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 5'd4, 4'd4, 32'h0000_0006, 128'hDEAD, 128'h0,
                     1'b1, 5'd4, 32'h0000_0006, 128'hDEAD, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'b11, 5'd6, 4'd8, 32'h0000_0005, 128'h0, stS,
                     1'b1, 5'd7, 32'h0000_0005, stS, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 5'd6, 4'd8, 32'h0000_0003, 128'h0, stS,
                     1'b1, 5'd6, 32'h0000_0003, 128'h0, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 5'd6, 4'd2, 32'h0000_0005, 128'hBEEF, stS,
                     1'b1, 5'd6, 32'h0000_0005, 128'hBEEF, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b11, 5'd7, 4'd2, 32'h0000_0005, 128'h42, 128'h0,
                     1'b1, 5'd7, 32'h0000_0005, 128'h42, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b11, 5'd8, 4'd2, 32'h0000_0005, 128'h0, 128'h0,
                     1'b0, 5'd0, 32'h0, 128'h0, 8'h05, 1'b1, 32'h1234_5678, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 5'd0, 4'd1, 32'h0000_0000, 128'h99, 128'h0,
                     1'b1, 5'd0, 32'h0000_0000, 128'h99, 8'h00, 1'b0, 32'h0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 5'd2, 4'd1, 32'hABCD_00FF, 128'h0, 128'h0,
                     1'b1, 5'd2, 32'hABCD_00FF, 128'h0, 8'h00, 1'b0, 32'h0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 5'd2, 4'd1, 32'hABCD_01FE, 128'h0, 128'h0,
                     1'b1, 5'd2, 32'hABCD_01FF, 128'h0, 8'hFE, 1'b1, 32'h0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 5'd4, 4'd4, 32'h1200_00FE, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0000_00AB}, 128'h0,
                     1'b1, 5'd5, 32'h1200_00FE, 128'hAB, 8'hFE, 1'b1, 32'h0000_00AB, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0};

        // Reset and check reset values
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b1, '0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset out_vld", 256'(out_vld), 256'(1'b0));
        checkOutput("reset out_msg", 256'(out_msg), 256'(0));
        checkOutput("reset node_id", 256'(node_id), 256'(0));
        checkOutput("reset enumerated", 256'(enumerated), 256'(1'b0));
        checkOutput("reset ctrl_out", 256'(ctrl_out), 256'(0));
        checkOutput("reset ctrl_pulse", 256'(ctrl_pulse), 256'(1'b0));
        checkOutput("reset bad_cnt", 256'(bad_cnt), 256'(0));
        checkOutput("reset in_rdy", 256'(in_rdy), 256'(1'b1));

        // Table of single-message vectors, one accept per cycle with out_rdy high
        for (int i = 0; i < NVEC; i++) begin
            expData = vecs[i].eData;
`ifdef ROU_MNG_NODE_STATS_EN
            if (vecs[i].isRpt) expData[15:0] = 16'(fwdModel);
`endif
            applyStimulus(mk(vecs[i].cmd, vecs[i].tags, vecs[i].bytes, vecs[i].addr, vecs[i].data),
                          1'b1, 1'b1, vecs[i].status);
            tick();
            expMsg = mk(vecs[i].cmd, vecs[i].eTags, vecs[i].bytes, vecs[i].eAddr, expData);
            checkOutput($sformatf("v%0d out_vld", i), 256'(out_vld), 256'(vecs[i].eVld));
            if (vecs[i].eVld) checkOutput($sformatf("v%0d out_msg", i), 256'(out_msg), 256'(expMsg));
            checkOutput($sformatf("v%0d node_id", i), 256'(node_id), 256'(vecs[i].eNode));
            checkOutput($sformatf("v%0d enumerated", i), 256'(enumerated), 256'(vecs[i].eEnum));
            checkOutput($sformatf("v%0d ctrl_out", i), 256'(ctrl_out), 256'(vecs[i].eCtrl));
            checkOutput($sformatf("v%0d ctrl_pulse", i), 256'(ctrl_pulse), 256'(vecs[i].ePulse));
            checkOutput($sformatf("v%0d bad_cnt", i), 256'(bad_cnt), 256'(vecs[i].eBad));
            if (vecs[i].isClr) fwdModel = 0;
            else if (vecs[i].isFwd) fwdModel++;
        end

        // Drain, then hold the output with out_rdy low while a CONTROL hit waits
        applyStimulus('0, 1'b0, 1'b1, '0);
        tick();
        checkOutput("drain out_vld", 256'(out_vld), 256'(1'b0));
        checkOutput("drain ctrl_pulse", 256'(ctrl_pulse), 256'(1'b0));
        msgA = mk(2'b00, 5'd3, 4'd1, 32'h0000_1000, 128'h1);
        applyStimulus(msgA, 1'b1, 1'b0, '0);
        tick();
        checkOutput("stall load out_vld", 256'(out_vld), 256'(1'b1));
        checkOutput("stall load out_msg", 256'(out_msg), 256'(msgA));
        msgB = mk(2'b11, 5'd4, 4'd4, 32'h0000_00FE, 128'h55);
        applyStimulus(msgB, 1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("stall%0d in_rdy", k), 256'(in_rdy), 256'(1'b0));
            tick();
            checkOutput($sformatf("stall%0d out_msg", k), 256'(out_msg), 256'(msgA));
            checkOutput($sformatf("stall%0d ctrl_out", k), 256'(ctrl_out), 256'(32'hAB));
            checkOutput($sformatf("stall%0d ctrl_pulse", k), 256'(ctrl_pulse), 256'(1'b0));
        end
        out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        checkOutput("release out_msg", 256'(out_msg), 256'(mk(2'b11, 5'd5, 4'd4, 32'h0000_00FE, 128'h55)));
        checkOutput("release ctrl_out", 256'(ctrl_out), 256'(32'h55));
        checkOutput("release ctrl_pulse", 256'(ctrl_pulse), 256'(1'b1));

        // Back-to-back stream: one message per cycle, each visible one cycle after its accept
        for (int k = 0; k < 5; k++) begin
            msgA = mk(2'b10, 5'd1, 4'd2, 32'h0000_2000 + 32'(k), 128'(k * 3 + 1));
            applyStimulus(msgA, 1'b1, 1'b1, '0);
            checkOutput($sformatf("stream%0d in_rdy", k), 256'(in_rdy), 256'(1'b1));
            tick();
            checkOutput($sformatf("stream%0d out_vld", k), 256'(out_vld), 256'(1'b1));
            checkOutput($sformatf("stream%0d out_msg", k), 256'(out_msg), 256'(msgA));
        end
        in_vld = 1'b0;
        tick();
        checkOutput("stream end out_vld", 256'(out_vld), 256'(1'b0));

        // 300 bad management messages saturate bad_cnt and produce no output
        applyStimulus(mk(2'b11, 5'd10, 4'd1, 32'h0, 128'h0), 1'b1, 1'b1, '0);
        for (int k = 0; k < 300; k++) tick();
        in_vld = 1'b0;
        checkOutput("sat bad_cnt", 256'(bad_cnt), 256'(8'hFF));
        checkOutput("sat out_vld", 256'(out_vld), 256'(1'b0));

        // rst while a message is held discards it
        msgA = mk(2'b00, 5'd9, 4'd3, 32'h0000_3000, 128'h3);
        applyStimulus(msgA, 1'b1, 1'b0, '0);
        tick();
        in_vld = 1'b0;
        checkOutput("prerst out_vld", 256'(out_vld), 256'(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst out_vld", 256'(out_vld), 256'(1'b0));
        checkOutput("rst out_msg", 256'(out_msg), 256'(0));
        checkOutput("rst node_id", 256'(node_id), 256'(0));
        checkOutput("rst enumerated", 256'(enumerated), 256'(1'b0));
        checkOutput("rst ctrl_out", 256'(ctrl_out), 256'(0));
        checkOutput("rst bad_cnt", 256'(bad_cnt), 256'(0));

        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
